// File: rtl/btb_assoc_pred_if.sv
// Fetch/EX-side bus of the branch target buffer: lookup, resolved-branch write-back and flush.
// The master drives PCs and strobes; the slave (the BTB) answers with the prediction and busy.
interface btb_assoc_pred_if;
   logic [31:0] pc;
   logic        valid;
   logic [31:0] target;
   logic        predicted_taken;
   logic        update;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic        flush;
   logic        busy;

   modport master (
      output pc, update, update_pc, update_target, update_taken, flush,
      input  valid, target, predicted_taken, busy
   );

   modport slave (
      input  pc, update, update_pc, update_target, update_taken, flush,
      output valid, target, predicted_taken, busy
   );
endinterface

// File: rtl/btb_assoc_pred.sv
// N-way set-associative BTB with 2-bit direction counters, tree pseudo-LRU replacement,
// allocate-on-taken write-back and a one-set-per-cycle flush sweep.
module btb_assoc_pred #(
   parameter int         SETS     = 8,
   parameter int         WAYS     = 2,
   parameter logic [1:0] CTR_INIT = 2'b10
) (
   input logic             clk,
   input logic             rst,
   btb_assoc_pred_if.slave bus
);
   localparam int IDX   = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TAG_W = 30 - IDX;

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   state_t             r_state;
   logic [IDX-1:0]     r_ptr;
   logic               r_busy;
   logic [WAYS-1:0]    r_valid  [SETS];
   logic [WAYS-2:0]    r_plru   [SETS];
   logic [1:0]         r_ctr    [SETS][WAYS];
   logic [TAG_W-1:0]   r_tag    [SETS][WAYS];
   logic [31:0]        r_target [SETS][WAYS];

   // Tree PLRU: each bit points at the subtree holding the victim (0 = lower ways).
   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
      logic [WAYS-2:0] r;
      r = bits;
      if (WAYS == 2) begin
         r[0] = ~way[0];
      end else begin
         r[0] = ~way[WAY_W-1];
         if (way[WAY_W-1]) r[WAYS-2]   = ~way[0];
         else              r[WAYS/2-1] = ~way[0];
      end
      return r;
   endfunction

   function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
      logic [WAY_W-1:0] v;
      v = '0;
      v[WAY_W-1] = bits[0];
      if (WAYS == 4) v[0] = bits[0] ? bits[WAYS-2] : bits[WAYS/2-1];
      return v;
   endfunction

   logic [IDX-1:0]   w_l_idx, w_u_idx;
   logic [TAG_W-1:0] w_l_tag, w_u_tag;
   logic             w_l_hit, w_u_hit, w_u_free;
   logic [WAY_W-1:0] w_l_way, w_u_hit_way, w_u_free_way, w_u_way;
   logic             w_u_en, w_u_touch, w_l_touch;
   logic [1:0]       w_ctr_cur, w_ctr_next;
   logic             w_unused_bits;

   assign w_l_idx       = bus.pc[IDX+1:2];
   assign w_l_tag       = bus.pc[31:IDX+2];
   assign w_u_idx       = bus.update_pc[IDX+1:2];
   assign w_u_tag       = bus.update_pc[31:IDX+2];
   assign w_unused_bits = ^{bus.pc[1:0], bus.update_pc[1:0]};

   // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_l_hit      = 1'b0;
      w_l_way      = '0;
      w_u_hit      = 1'b0;
      w_u_hit_way  = '0;
      w_u_free     = 1'b0;
      w_u_free_way = '0;
      // Descending scan so the lowest-numbered free way is the one that sticks.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_l_idx][w] && r_tag[w_l_idx][w] == w_l_tag) begin
            w_l_hit = 1'b1;
            w_l_way = WAY_W'(w);
         end
         if (r_valid[w_u_idx][w] && r_tag[w_u_idx][w] == w_u_tag) begin
            w_u_hit     = 1'b1;
            w_u_hit_way = WAY_W'(w);
         end
         if (!r_valid[w_u_idx][w]) begin
            w_u_free     = 1'b1;
            w_u_free_way = WAY_W'(w);
         end
      end
   end

   assign w_u_way = w_u_hit  ? w_u_hit_way :
                    w_u_free ? w_u_free_way : plru_victim(r_plru[w_u_idx]);

   assign bus.valid           = (r_state == S_IDLE) && w_l_hit;
   assign bus.target          = bus.valid ? r_target[w_l_idx][w_l_way] : 32'h0;
   assign bus.predicted_taken = bus.valid && r_ctr[w_l_idx][w_l_way][1];
   assign bus.busy            = r_busy;

   // A flush in the same cycle discards the update.
   assign w_u_en    = bus.update && (r_state == S_IDLE) && !bus.flush;
   assign w_u_touch = w_u_en && (w_u_hit || bus.update_taken);
   assign w_l_touch = bus.valid && !(w_u_en && (w_u_idx == w_l_idx));

   always_comb begin
      w_ctr_cur = r_ctr[w_u_idx][w_u_way];
      if (!w_u_hit)              w_ctr_next = CTR_INIT;
      else if (bus.update_taken) w_ctr_next = (w_ctr_cur == 2'd3) ? 2'd3 : w_ctr_cur + 2'd1;
      else                       w_ctr_next = (w_ctr_cur == 2'd0) ? 2'd0 : w_ctr_cur - 2'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_plru[s]  <= '0;
            for (int w = 0; w < WAYS; w++) r_ctr[s][w] <= 2'd0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.flush) begin
                  r_state <= S_SWEEP;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
               if (w_l_touch) r_plru[w_l_idx] <= plru_touch(r_plru[w_l_idx], w_l_way);
               if (w_u_touch) begin
                  r_valid[w_u_idx][w_u_way] <= 1'b1;
                  r_ctr[w_u_idx][w_u_way]   <= w_ctr_next;
                  r_plru[w_u_idx]           <= plru_touch(r_plru[w_u_idx], w_u_way);
               end
            end
            S_SWEEP: begin
               r_valid[r_ptr] <= '0;
               r_plru[r_ptr]  <= '0;
               if (r_ptr == IDX'(SETS - 1)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: tags and targets carry no reset; the valid bits alone decide whether an entry is live.
   always_ff @(posedge clk) begin
      if (w_u_en && bus.update_taken) begin
         r_target[w_u_idx][w_u_way] <= bus.update_target;
         if (!w_u_hit) r_tag[w_u_idx][w_u_way] <= w_u_tag;
      end
   end
endmodule
